accel_mmio_bridge: RTL and testbench
====================================

# accel_mmio_bridge

Parametrised memory-mapped slave that connects a SoC core-local bus to one accelerator core. It provides a byte-maskable CSR bank, a control/status register with a start/busy/done handshake and interrupt, and NUM_SRAM windowed SRAM channels. All responses are pipelined with fixed 2-cycle latency, so back-to-back requests are accepted every cycle. It replaces the single-purpose wrapper generation with a reusable block that every 3DGS accelerator can instantiate.

## Interface
- ADDR_W, 64, bus address width
- DATA_W, 64, bus/CSR/SRAM data width (multiple of 8)
- NUM_CSR, 4, number of DATA_W-bit config CSRs (1..16)
- NUM_SRAM, 2, number of SRAM windows (1..14)
- SRAM_IDX_W, 10, word-index width per SRAM window (≤17)
- BASE_ADDR, 64'h6000_0000, block base; bits [27:0] must be zero
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- mem_req_i  in  1  request valid (always accepted)
- mem_write_en_i  in  1  1 = write, 0 = read
- mem_byte_en_i  in  DATA_W/8  byte enables
- mem_addr_i  in  ADDR_W  byte address; bits [2:0] ignored
- mem_wdata_i  in  DATA_W  write data
- mem_rdata_o  out  DATA_W  response data
- mem_rvalid_o  out  1  response valid, one per request
- mem_err_o  out  1  decode error, qualified by mem_rvalid_o
- csr_o  out  NUM_CSR*DATA_W  CSR contents, CSR k at [k*DATA_W +: DATA_W]
- start_o  out  1  one-cycle core start pulse
- core_busy_i  in  1  core is executing
- core_done_i  in  1  one-cycle completion pulse
- irq_o  out  1  level interrupt
- sram_req_o / sram_we_o  out  NUM_SRAM  per-channel request / write
- sram_be_o  out  NUM_SRAM*DATA_W/8  per-channel byte enables
- sram_addr_o  out  NUM_SRAM*SRAM_IDX_W  per-channel word index
- sram_wdata_o  out  NUM_SRAM*DATA_W  per-channel write data
- sram_rdata_i  in  NUM_SRAM*DATA_W  per-channel read data, valid 1 cycle after req

## Operation
- The decode hits only when addr[ADDR_W-1:28] == BASE_ADDR[ADDR_W-1:28]. The region is addr[27:20].
- Region 0x00: CSR k = addr[19:3]. Valid when k < NUM_CSR. Writes merge per byte: a byte updates only where be=1, and all other bytes are retained.
- Region 0x01..NUM_SRAM: SRAM channel c = region-1. Valid when addr[19:SRAM_IDX_W+3] == 0. The block drives the channel's req/we/be/addr = addr[SRAM_IDX_W+2:3]/wdata combinationally in the request cycle. All other channels see req=0.
- Region 0x0F, offset 0x0, CTRL:
  - bit0 START: W1 issues start_o; reads 0.
  - bit1 BUSY: read-only, reflects core_busy_i.
  - bit2 DONE: sticky, W1C.
  - bit3 IRQ_EN: RW.
  - bit4 ERR: sticky, W1C.
  - Byte enable 0 must be set for a CTRL write to take effect.
- Region 0x0F, offset 0x8, DONE_CNT: read-only 32-bit count of core_done_i pulses, zero-extended, wraps at 2^32.
- Any other address is a decode error:
  - write is dropped;
  - read data = 64'hDEADBEEF_DEADBEEF (replicated to DATA_W);
  - mem_err_o = 1 with the response;
  - ERR is set.
- START handling:
  - START written while core_busy_i=1 or start_o is already pending: start_o is not pulsed and ERR is set.
  - Otherwise start_o = 1 in cycle T+1, and DONE is cleared in the same cycle.
- Simultaneous core_done_i and W1C of DONE: set wins.
- Simultaneous decode error and W1C of ERR: set wins.
- irq_o = IRQ_EN & DONE (registered state, no comb path from the bus).
- Writes also produce a response: mem_rvalid_o=1, mem_rdata_o=0 (or the error pattern with mem_err_o on a miss).

## Timing
- Request accepted in cycle T. The response (rvalid, rdata, err) is registered and valid in cycle T+2 only.
- Stage 1 (T→T+1) registers the region, channel, error flag and CSR/CTRL read value.
- Stage 2 (T+1→T+2) selects between the stage-1 value and sram_rdata_i of the stage-1 channel.
- One request per cycle is sustained. Responses are in order. There is no backpressure.
- CSR/CTRL writes are visible on csr_o and in register state at T+1. A read at T+1 returns the new value.
- Reset values: all outputs 0, csr_o 0, CTRL 0, DONE_CNT 0, pipeline valid bits 0.
- Asynchronous reset mid-transaction discards in-flight responses. No rvalid is produced for them after release.

## Test plan
- Write CSR1 = 64'h1122_3344_5566_7788 with be=8'hFF, then write 64'hAAAA..AA with be=8'h0F, then read CSR1 → 64'h1122_3344_AAAA_AAAA at T+2, and csr_o matches.
- Back-to-back writes to SRAM ch0 idx 5 and ch1 idx 5, then reads of both on consecutive cycles → responses in order on consecutive cycles with the written data. Only the addressed channel's sram_req_o is high on each cycle.
- Set IRQ_EN, write START → start_o pulses once at T+1. Pulse core_done_i → DONE=1, irq_o=1, DONE_CNT=1. W1C DONE in the same cycle as a second core_done_i → DONE stays 1.
- Write START while core_busy_i=1 → no start_o and ERR=1. A subsequent W1C of ERR → ERR=0.
- Read 0x6030_0000 (unmapped) and CSR index NUM_CSR → DEADBEEF pattern, mem_err_o=1, ERR set.
- Assert rstn_i low between a request and its response → no rvalid after release, and all registers read 0.

Source files
------------

// File: rtl/accel_mmio_bridge.sv
// Memory-mapped slave bridging the core-local bus to one accelerator: CSR bank,
// control/status with start/done handshake, and windowed SRAM channels, 2-cycle responses.
module accel_mmio_bridge #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int NUM_CSR    = 4,
  parameter int NUM_SRAM   = 2,
  parameter int SRAM_IDX_W = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h6000_0000)
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           mem_req_i,
  input  logic                           mem_write_en_i,
  input  logic [DATA_W/8-1:0]            mem_byte_en_i,
  input  logic [ADDR_W-1:0]              mem_addr_i,
  input  logic [DATA_W-1:0]              mem_wdata_i,
  output logic [DATA_W-1:0]              mem_rdata_o,
  output logic                           mem_rvalid_o,
  output logic                           mem_err_o,
  output logic [NUM_CSR*DATA_W-1:0]      csr_o,
  output logic                           start_o,
  input  logic                           core_busy_i,
  input  logic                           core_done_i,
  output logic                           irq_o,
  output logic [NUM_SRAM-1:0]            sram_req_o,
  output logic [NUM_SRAM-1:0]            sram_we_o,
  output logic [NUM_SRAM*DATA_W/8-1:0]   sram_be_o,
  output logic [NUM_SRAM*SRAM_IDX_W-1:0] sram_addr_o,
  output logic [NUM_SRAM*DATA_W-1:0]     sram_wdata_o,
  input  logic [NUM_SRAM*DATA_W-1:0]     sram_rdata_i
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [7:0]  CTRL_REGION = 8'h0F;
  localparam logic [7:0]  LAST_SRAM   = 8'(NUM_SRAM);
  localparam logic [16:0] CSR_LIMIT   = 17'(NUM_CSR);

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] err_pattern();
    logic [31:0]       pat;
    logic [DATA_W-1:0] r;
    pat = 32'hDEAD_BEEF;
    r   = '0;
    for (int b = 0; b < BE_W; b++)
      r[b*8 +: 8] = pat[(b % 4)*8 +: 8];
    return r;
  endfunction

  localparam logic [DATA_W-1:0] ERR_PAT = err_pattern();

  // ---- stage 0: request decode (combinational, request cycle)
  logic        hit_base_p0, is_csr_p0, is_sram_p0, is_ctrl_p0, is_cnt_p0;
  logic        wr_p0, rd_p0, dec_err_p0;
  logic [7:0]  region_p0;
  logic [16:0] word_p0;
  logic [3:0]  chan_p0;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^mem_addr_i[2:0];
  assign hit_base_p0 = (mem_addr_i[ADDR_W-1:28] == BASE_ADDR[ADDR_W-1:28]);
  assign region_p0   = mem_addr_i[27:20];
  assign word_p0     = mem_addr_i[19:3];
  assign chan_p0     = region_p0[3:0] - 4'd1;

  assign is_csr_p0  = hit_base_p0 && (region_p0 == 8'd0) && (word_p0 < CSR_LIMIT);
  assign is_sram_p0 = hit_base_p0 && (region_p0 != 8'd0) && (region_p0 <= LAST_SRAM)
                      && ((word_p0 >> SRAM_IDX_W) == '0);
  assign is_ctrl_p0 = hit_base_p0 && (region_p0 == CTRL_REGION) && (word_p0 == 17'd0);
  assign is_cnt_p0  = hit_base_p0 && (region_p0 == CTRL_REGION) && (word_p0 == 17'd1);

  assign wr_p0      = mem_req_i &&  mem_write_en_i;
  assign rd_p0      = mem_req_i && !mem_write_en_i;
  assign dec_err_p0 = mem_req_i && !(is_csr_p0 || is_sram_p0 || is_ctrl_p0 || is_cnt_p0);

  // SRAM channels are driven straight from the bus; only req/we are channel-qualified
  for (genvar c = 0; c < NUM_SRAM; c++) begin : g_sram
    assign sram_req_o[c] = mem_req_i && is_sram_p0 && (chan_p0 == 4'(c));
    assign sram_we_o[c]  = sram_req_o[c] && mem_write_en_i;
    assign sram_be_o[c*BE_W +: BE_W]                = mem_byte_en_i;
    assign sram_addr_o[c*SRAM_IDX_W +: SRAM_IDX_W] = mem_addr_i[SRAM_IDX_W+2:3];
    assign sram_wdata_o[c*DATA_W +: DATA_W]        = mem_wdata_i;
  end

  // ---- control/status state
  logic [DATA_W-1:0] csr_q [NUM_CSR];
  logic              done_q, irq_en_q, err_q;
  logic [31:0]       done_cnt_q;
  logic              ctrl_wr_p0, start_req_p0, start_fire_p0, start_rej_p0;

  assign ctrl_wr_p0    = wr_p0 && is_ctrl_p0 && mem_byte_en_i[0];
  assign start_req_p0  = ctrl_wr_p0 && mem_wdata_i[0];
  assign start_fire_p0 = start_req_p0 && !core_busy_i && !start_o;
  assign start_rej_p0  = start_req_p0 && !start_fire_p0;
  assign irq_o         = irq_en_q && done_q;

  for (genvar k = 0; k < NUM_CSR; k++) begin : g_csr_out
    assign csr_o[k*DATA_W +: DATA_W] = csr_q[k];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < NUM_CSR; k++) csr_q[k] <= '0;
      start_o    <= 1'b0;
      done_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      err_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CSR; k++)
        if (wr_p0 && is_csr_p0 && (word_p0 == 17'(k)))
          csr_q[k] <= merge_bytes(csr_q[k], mem_wdata_i, mem_byte_en_i);
      start_o <= start_fire_p0;
      // sticky bits: a set event always beats a clear in the same cycle
      if (core_done_i)                                      done_q <= 1'b1;
      else if (start_fire_p0 || (ctrl_wr_p0 && mem_wdata_i[2])) done_q <= 1'b0;
      if (dec_err_p0 || start_rej_p0)          err_q <= 1'b1;
      else if (ctrl_wr_p0 && mem_wdata_i[4])   err_q <= 1'b0;
      if (ctrl_wr_p0) irq_en_q <= mem_wdata_i[3];
      if (core_done_i) done_cnt_q <= done_cnt_q + 32'd1;
    end
  end

  logic [DATA_W-1:0] csr_rd_p0, rd_val_p0;

  always_comb begin
    csr_rd_p0 = '0;
    for (int k = 0; k < NUM_CSR; k++)
      if (word_p0 == 17'(k)) csr_rd_p0 = csr_q[k];
  end

  always_comb begin
    rd_val_p0 = '0;
    if (dec_err_p0)      rd_val_p0 = ERR_PAT;
    else if (!rd_p0)     rd_val_p0 = '0;
    else if (is_csr_p0)  rd_val_p0 = csr_rd_p0;
    else if (is_ctrl_p0) rd_val_p0 = DATA_W'({err_q, irq_en_q, done_q, core_busy_i, 1'b0});
    else if (is_cnt_p0)  rd_val_p0 = DATA_W'(done_cnt_q);
  end

  // ---- stage 1: register decode result and local read value
  logic              vld_p1, err_p1, sram_rd_p1;
  logic [3:0]        chan_p1;
  logic [DATA_W-1:0] rdata_p1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_p1     <= 1'b0;
      err_p1     <= 1'b0;
      sram_rd_p1 <= 1'b0;
      chan_p1    <= '0;
    end else begin
      vld_p1     <= mem_req_i;
      err_p1     <= dec_err_p0;
      sram_rd_p1 <= rd_p0 && is_sram_p0;
      chan_p1    <= chan_p0;
    end
  end

  always_ff @(posedge clk_i) begin
    rdata_p1 <= rd_val_p0;
  end

  logic [DATA_W-1:0] sram_sel_p1;

  always_comb begin
    sram_sel_p1 = '0;
    for (int c = 0; c < NUM_SRAM; c++)
      if (chan_p1 == 4'(c)) sram_sel_p1 = sram_rdata_i[c*DATA_W +: DATA_W];
  end

  // ---- stage 2: registered response
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_rvalid_o <= 1'b0;
      mem_err_o    <= 1'b0;
      mem_rdata_o  <= '0;
    end else begin
      mem_rvalid_o <= vld_p1;
      mem_err_o    <= vld_p1 && err_p1;
      mem_rdata_o  <= !vld_p1 ? '0 : (sram_rd_p1 ? sram_sel_p1 : rdata_p1);
    end
  end

endmodule

// File: tb/tb_accel_mmio_bridge.sv
// Bench for accel_mmio_bridge: directed steps plus random traffic scored against
// a transaction-level model of the register map, SRAM windows and handshake.
module tb_accel_mmio_bridge;
  localparam int DW = 64;
  localparam int NC = 4;
  localparam int NS = 2;
  localparam int IW = 10;
  localparam int BW = 8;
  localparam logic [63:0] BASE = 64'h6000_0000;
  localparam logic [63:0] CTRL = 64'h60F0_0000;
  localparam logic [63:0] CNT  = 64'h60F0_0008;
  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_DEAD_BEEF;

  logic clk = 1'b0;
  logic rstn;
  logic mem_req, mem_we, core_busy, core_done;
  logic [BW-1:0] mem_be;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_rvalid, mem_err, start, irq;
  logic [NC*DW-1:0] csr;
  logic [NS-1:0] sram_req, sram_we;
  logic [NS*BW-1:0] sram_be;
  logic [NS*IW-1:0] sram_addr;
  logic [NS*DW-1:0] sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  accel_mmio_bridge dut (
    .clk_i(clk), .rstn_i(rstn),
    .mem_req_i(mem_req), .mem_write_en_i(mem_we), .mem_byte_en_i(mem_be),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(mem_rdata), .mem_rvalid_o(mem_rvalid), .mem_err_o(mem_err),
    .csr_o(csr), .start_o(start), .core_busy_i(core_busy), .core_done_i(core_done),
    .irq_o(irq),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_be_o(sram_be),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  // external SRAM macros: 1-cycle read latency
  logic [63:0] env_mem [NS][1024];
  logic env_ready = 1'b0;
  always @(posedge clk) begin
    if (!env_ready) begin
      for (int c = 0; c < NS; c++)
        for (int i = 0; i < 1024; i++) env_mem[c][i] <= '0;
      sram_rdata <= '0;
      env_ready  <= 1'b1;
    end else begin
      for (int c = 0; c < NS; c++) begin
        if (sram_req[c]) begin
          if (sram_we[c]) begin
            for (int b = 0; b < BW; b++)
              if (sram_be[c*BW+b])
                env_mem[c][sram_addr[c*IW +: IW]][b*8 +: 8] <= sram_wdata[c*DW + b*8 +: 8];
          end else begin
            sram_rdata[c*DW +: DW] <= env_mem[c][sram_addr[c*IW +: IW]];
          end
        end
      end
    end
  end

  // reference model state
  logic [63:0] m_csr [NC];
  logic [63:0] m_sram [NS][1024];
  logic m_done, m_irqen, m_err, m_start;
  logic [31:0] m_cnt;
  logic pend_v, pend_err;
  logic [63:0] pend_data, obs_rdata;
  logic obs_err;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) m_csr[k] = '0;
    m_done = 0; m_irqen = 0; m_err = 0; m_start = 0; m_cnt = '0;
    pend_v = 0; pend_err = 0; pend_data = '0;
  endtask

  task automatic chk_reset_state();
    chk("rst_rvalid", 64'(mem_rvalid), 64'd0);
    chk("rst_err", 64'(mem_err), 64'd0);
    chk("rst_rdata", mem_rdata, 64'd0);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    for (int k = 0; k < NC; k++) chk("rst_csr", csr[k*DW +: DW], 64'd0);
  endtask

  // one bus cycle: drive, check combinational SRAM side, clock, check registered outputs
  task automatic cycle(input logic req, input logic we, input logic [7:0] be,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic done_in, input logic busy);
    logic hit, k_csr, k_sram, k_ctrl, k_cnt, derr, sreq, fire, rej, cw;
    int rg, w, ch;
    logic [63:0] rd;
    logic [NS-1:0] exp_req;
    mem_req = req; mem_we = we; mem_be = be; mem_addr = addr; mem_wdata = wd;
    core_done = done_in; core_busy = busy;
    hit = (addr[63:28] == 36'h6);
    rg = int'(addr[27:20]);
    w  = int'(addr[19:3]);
    ch = rg - 1;
    k_csr  = hit && rg == 0 && w < NC;
    k_sram = hit && rg >= 1 && rg <= NS && w < 1024;
    k_ctrl = hit && rg == 15 && w == 0;
    k_cnt  = hit && rg == 15 && w == 1;
    derr   = req && !(k_csr || k_sram || k_ctrl || k_cnt);
    #1;
    exp_req = '0;
    if (req && k_sram) exp_req[ch] = 1'b1;
    chk("sram_req", 64'(sram_req), 64'(exp_req));
    chk("sram_we", 64'(sram_we), we ? 64'(exp_req) : 64'd0);
    if (req && k_sram) begin
      chk("sram_addr", 64'(sram_addr[ch*IW +: IW]), 64'(w));
      chk("sram_wdata", sram_wdata[ch*DW +: DW], wd);
      chk("sram_be", 64'(sram_be[ch*BW +: BW]), 64'(be));
    end
    if (derr)        rd = DEAD;
    else if (we)     rd = '0;
    else if (k_csr)  rd = m_csr[w];
    else if (k_sram) rd = m_sram[ch][w];
    else if (k_ctrl) rd = {59'd0, m_err, m_irqen, m_done, busy, 1'b0};
    else             rd = {32'd0, m_cnt};
    sreq = req && we && k_ctrl && be[0] && wd[0];
    fire = sreq && !busy && !m_start;
    rej  = sreq && !fire;
    cw   = req && we && k_ctrl && be[0];
    if (req && we && k_csr)
      for (int b = 0; b < BW; b++) if (be[b]) m_csr[w][b*8 +: 8] = wd[b*8 +: 8];
    if (req && we && k_sram)
      for (int b = 0; b < BW; b++) if (be[b]) m_sram[ch][w][b*8 +: 8] = wd[b*8 +: 8];
    if (done_in) m_done = 1;
    else if (fire || (cw && wd[2])) m_done = 0;
    if (derr || rej) m_err = 1;
    else if (cw && wd[4]) m_err = 0;
    if (cw) m_irqen = wd[3];
    m_start = fire;
    if (done_in) m_cnt = m_cnt + 32'd1;
    @(posedge clk);
    #1;
    chk("rvalid", 64'(mem_rvalid), 64'(pend_v));
    if (pend_v) begin
      chk("resp_err", 64'(mem_err), 64'(pend_err));
      chk("resp_data", mem_rdata, pend_data);
    end
    chk("start_o", 64'(start), 64'(m_start));
    chk("irq_o", 64'(irq), 64'(m_irqen & m_done));
    for (int k = 0; k < NC; k++) chk("csr_o", csr[k*DW +: DW], m_csr[k]);
    if (mem_rvalid) begin obs_rdata = mem_rdata; obs_err = mem_err; end
    pend_v = req; pend_err = derr; pend_data = rd;
  endtask

  task automatic idle(input logic done_in);
    cycle(1'b0, 1'b0, 8'h00, 64'd0, 64'd0, done_in, 1'b0);
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = BASE | 64'($urandom_range(0, 7));
    case ($urandom_range(0, 8))
      0:       a |= 64'($urandom_range(0, NC)) << 3;
      1, 2:    a |= (64'($urandom_range(1, NS)) << 20) | (64'($urandom_range(0, 7)) << 3);
      3:       a |= (64'($urandom_range(1, NS)) << 20) | (64'($urandom_range(1024, 1100)) << 3);
      4, 5:    a |= 64'hF << 20;
      6:       a |= (64'hF << 20) | 64'h8;
      7:       a |= 64'($urandom_range(3, 14)) << 20;
      default: a = 64'h7000_0000 | (64'($urandom_range(0, 255)) << 3);
    endcase
    return a;
  endfunction

  initial begin
    logic r_we;
    logic [7:0] r_be;
    logic [63:0] r_a, r_d;
    rstn = 1'b0;
    mem_req = 0; mem_we = 0; mem_be = '0; mem_addr = '0; mem_wdata = '0;
    core_busy = 0; core_done = 0;
    obs_rdata = '0; obs_err = 0;
    model_reset();
    for (int c = 0; c < NS; c++)
      for (int i = 0; i < 1024; i++) m_sram[c][i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    @(negedge clk);
    rstn = 1'b1;

    // CSR byte-merge
    cycle(1, 1, 8'hFF, BASE + 64'h8, 64'h1122_3344_5566_7788, 0, 0);
    cycle(1, 1, 8'h0F, BASE + 64'h8, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0);
    chk("csr1_merge", csr[127:64], 64'h1122_3344_AAAA_AAAA);
    cycle(1, 0, 8'hFF, BASE + 64'h8, 64'd0, 0, 0);
    idle(0);
    chk("csr1_read", obs_rdata, 64'h1122_3344_AAAA_AAAA);
    idle(0);

    // SRAM windows back-to-back
    cycle(1, 1, 8'hFF, 64'h6010_0028, 64'h0123_4567_89AB_CDEF, 0, 0);
    cycle(1, 1, 8'hFF, 64'h6020_0028, 64'hFEDC_BA98_7654_3210, 0, 0);
    cycle(1, 0, 8'hFF, 64'h6010_0028, 64'd0, 0, 0);
    cycle(1, 0, 8'hFF, 64'h6020_0028, 64'd0, 0, 0);
    chk("sram_ch0_read", obs_rdata, 64'h0123_4567_89AB_CDEF);
    idle(0);
    chk("sram_ch1_read", obs_rdata, 64'hFEDC_BA98_7654_3210);
    idle(0);

    // start / done / irq
    cycle(1, 1, 8'h01, CTRL, 64'h8, 0, 0);
    cycle(1, 1, 8'h01, CTRL, 64'h9, 0, 0);
    chk("start_pulse", 64'(start), 64'd1);
    idle(0);
    chk("start_single", 64'(start), 64'd0);
    idle(1);
    chk("irq_after_done", 64'(irq), 64'd1);
    cycle(1, 0, 8'hFF, CNT, 64'd0, 0, 0);
    idle(0);
    chk("done_cnt_1", obs_rdata, 64'd1);
    cycle(1, 1, 8'h01, CTRL, 64'hC, 1, 0);
    chk("done_set_wins", 64'(irq), 64'd1);
    cycle(1, 0, 8'hFF, CTRL, 64'd0, 0, 0);
    idle(0);
    chk("ctrl_done_irqen", obs_rdata, 64'hC);
    cycle(1, 1, 8'h01, CTRL, 64'hC, 0, 0);
    chk("irq_cleared", 64'(irq), 64'd0);

    // start rejected while busy, then W1C ERR
    cycle(1, 1, 8'h01, CTRL, 64'h9, 0, 1);
    chk("no_start_busy", 64'(start), 64'd0);
    cycle(1, 0, 8'hFF, CTRL, 64'd0, 0, 0);
    idle(0);
    chk("ctrl_err_set", obs_rdata, 64'h18);
    cycle(1, 1, 8'h01, CTRL, 64'h18, 0, 0);
    cycle(1, 0, 8'hFF, CTRL, 64'd0, 0, 0);
    idle(0);
    chk("ctrl_err_clr", obs_rdata, 64'h8);

    // start while a start is pending; byte-enable 0 gating
    cycle(1, 1, 8'h01, CTRL, 64'h9, 0, 0);
    cycle(1, 1, 8'h01, CTRL, 64'h9, 0, 0);
    chk("no_start_pending", 64'(start), 64'd0);
    cycle(1, 0, 8'hFF, CTRL, 64'd0, 0, 0);
    idle(0);
    chk("ctrl_err_pending", obs_rdata, 64'h18);
    cycle(1, 1, 8'hFE, CTRL, 64'h19, 0, 0);
    chk("no_start_be0", 64'(start), 64'd0);
    cycle(1, 1, 8'h01, CTRL, 64'h18, 0, 0);

    // decode errors
    cycle(1, 0, 8'hFF, 64'h6030_0000, 64'd0, 0, 0);
    cycle(1, 0, 8'hFF, BASE + 64'h20, 64'd0, 0, 0);
    chk("unmapped_data", obs_rdata, DEAD);
    chk("unmapped_err", 64'(obs_err), 64'd1);
    idle(0);
    chk("csr_oob_data", obs_rdata, DEAD);
    chk("csr_oob_err", 64'(obs_err), 64'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r_a  = rand_addr();
      r_we = 1'($urandom_range(0, 1));
      r_d  = {$urandom, $urandom};
      r_be = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      cycle($urandom_range(0, 3) != 0, r_we, r_be, r_a, r_d,
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    // asynchronous reset with a response in flight
    cycle(1, 1, 8'hFF, BASE, 64'h5555_6666_7777_8888, 0, 0);
    cycle(1, 0, 8'hFF, BASE, 64'd0, 0, 0);
    mem_req = 0; mem_we = 0; core_busy = 0; core_done = 0;
    rstn = 1'b0;
    #1;
    chk_reset_state();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    idle(0);
    idle(0);
    idle(0);
    for (int k = 0; k < NC; k++) cycle(1, 0, 8'hFF, BASE + 64'(k*8), 64'd0, 0, 0);
    cycle(1, 0, 8'hFF, CTRL, 64'd0, 0, 0);
    cycle(1, 0, 8'hFF, CNT, 64'd0, 0, 0);
    idle(0);
    idle(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
